serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial subtractor: computes diff = a - b - bin, LSB first, one bit per clock.
- Uses a single full-subtractor cell and a registered borrow; the inverse arithmetic counterpart to the combinational full-adder cells.
- Operands are captured on a valid/ready input handshake. The result is held on a valid/ready output handshake.
- Area-minimal subtraction for datapaths that can tolerate WIDTH-cycle latency.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 1..32).
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand request
- in_ready  output  1  block can accept operands
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- bin  input  1  borrow-in
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- diff  output  WIDTH  a - b - bin, modulo 2^WIDTH
- bout  output  1  borrow-out (1 when a < b + bin, unsigned)
- ovf  output  1  signed overflow (only present with the optional feature)

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, in_ready=1, out_valid=0, diff=0, bout=0, ovf=0, counter=0, borrow reg=0. The block is usable on the first rising clk edge after rst_n goes high.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at edge T: capture a and b into shift registers, load the borrow reg with bin, clear the counter, go to SHIFT.
  - Operands may change after T.
- SHIFT:
  - in_ready=0.
  - Each edge processes bit i = LSB of the shift registers: d_i = a_i ^ b_i ^ br; br' = (~a_i & b_i) | (~(a_i ^ b_i) & br).
  - d_i shifts into the diff register from the MSB side. Both operand registers shift right. The counter increments.
  - At the edge where the counter reaches WIDTH-1 (edge T+WIDTH): load bout with the final br', go to DONE.
- DONE:
  - out_valid=1 from edge T+WIDTH. diff and bout are stable and held while out_valid=1.
  - On out_valid&out_ready: go to IDLE; out_valid deasserts on the next edge.
  - diff and bout keep their last value until the next result overwrites them.
- Latency: out_valid rises exactly WIDTH cycles after the accepting edge.
- Throughput: one operation per WIDTH+2 cycles minimum. Operations never overlap: in_ready=0 in SHIFT and DONE.
- Boundary conditions:
  - in_valid during SHIFT/DONE is ignored and no operands are captured.
  - out_ready held high before DONE has no effect.
  - WIDTH=1: SHIFT lasts one cycle.
  - Wrap-around: a<b yields the 2^WIDTH-modular diff with bout=1.
  - bin=1 with a==b yields all-ones diff with bout=1.
  - rst_n asserted mid-SHIFT or in DONE aborts the operation immediately. Outputs take reset values and no result is emitted.
  - Unknown (X) on a, b or bin outside an accepting edge must not propagate into the outputs.

Optional Feature:
- Macro: SERIAL_SUB_OVERFLOW_EN.
- Defined:
  - ovf port and logic are present.
  - The borrow into the MSB is captured on the final SHIFT edge.
  - ovf = borrow_into_msb ^ bout, registered with diff and held under the same rules.
  - ovf is reset to 0.
- Undefined:
  - ovf port and logic are absent; no other behaviour changes.

Test Plan:
- WIDTH=8, a=0x35, b=0x12, bin=0 -> diff=0x23, bout=0; out_valid rises exactly 8 cycles after the accepting edge.
- a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1; also a=0x10, b=0x10, bin=1 -> diff=0xFF, bout=1.
- Backpressure: result ready with out_ready=0 for 5 cycles, in_valid=1 throughout with a new operand pair. Required: diff/bout/out_valid held, in_ready=0, new operands ignored. Releasing out_ready completes the handshake, and in_ready=1 on the following cycle.
- Drive rst_n low on the 3rd SHIFT cycle (a=0xAA, b=0x55). Required: out_valid=0 and diff=0 immediately, in_ready=1 after release. A following a=0xAA, b=0x55 returns diff=0x55, bout=0.
- WIDTH=1 sweep of all 8 (a, b, bin) combinations -> diff/bout match the full-subtractor truth table, each with 1-cycle latency.
- With SERIAL_SUB_OVERFLOW_EN:
  - a=0x80, b=0x01 -> diff=0x7F, ovf=1.
  - a=0x7F, b=0xFF -> diff=0x80, ovf=1.
  - a=0x05, b=0x03 -> diff=0x02, ovf=0.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one full-subtractor cell and a registered borrow.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout
`ifdef SERIAL_SUB_OVERFLOW_EN
   ,
   output logic             ovf
`endif
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_nx;
   logic [CNT_W-1:0] cnt;
   logic             br, br_nx, d_bit, last_bit;

   // Handshake: a transfer happens on a rising edge where valid and ready are both high.
   // in_ready is high only in IDLE; out_valid is high only in DONE, so operations never overlap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   assign last_bit = (cnt == CNT_W'(WIDTH - 1));

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = SHIFT;
         end
         SHIFT: begin
            if (last_bit) state_nx = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Full-subtractor cell on the operand LSBs; result bits enter from the MSB side.
   always_comb begin
      d_bit            = a_sr[0] ^ b_sr[0] ^ br;
      br_nx            = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
      res_nx           = res_sr >> 1;
      res_nx[WIDTH-1]  = d_bit;
   end

   // diff/bout live in separate output registers so they stay stable while the next result shifts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         br     <= 1'b0;
         cnt    <= '0;
         diff   <= '0;
         bout   <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
         ovf    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sr   <= a;
                  b_sr   <= b;
                  br     <= bin;
                  res_sr <= '0;
                  cnt    <= '0;
               end
            end
            SHIFT: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               res_sr <= res_nx;
               br     <= br_nx;
               cnt    <= cnt + CNT_W'(1);
               if (last_bit) begin
                  diff <= res_nx;
                  bout <= br_nx;
`ifdef SERIAL_SUB_OVERFLOW_EN
                  // br here is the borrow into the MSB cell.
                  ovf  <= br ^ br_nx;
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: WIDTH=8 and WIDTH=1 instances against an arithmetic model.
// Define SERIAL_SUB_OVERFLOW_EN to also check the ovf output.
module tb_serial_subtractor;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic       in_valid8, in_ready8, bin8, out_valid8, out_ready8, bout8;
   logic [7:0] a8, b8, diff8;
   logic       in_valid1, in_ready1, bin1, out_valid1, out_ready1, bout1;
   logic [0:0] a1, b1, diff1;
`ifdef SERIAL_SUB_OVERFLOW_EN
   logic       ovf8, ovf1;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   logic [9:0] exp_q[$];

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8), .bin(bin8),
      .out_valid(out_valid8), .out_ready(out_ready8), .diff(diff8), .bout(bout8)
`ifdef SERIAL_SUB_OVERFLOW_EN
      , .ovf(ovf8)
`endif
   );

   serial_subtractor #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1), .bin(bin1),
      .out_valid(out_valid1), .out_ready(out_ready1), .diff(diff1), .bout(bout1)
`ifdef SERIAL_SUB_OVERFLOW_EN
      , .ovf(ovf1)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Returns {ovf, bout, diff} from plain integer arithmetic.
   function automatic logic [9:0] model8(input logic [7:0] av, input logic [7:0] bv, input logic bv_in);
      int ua, ub, ud, sa, sb, sd;
      logic bo, ov;
      ua = int'(av);
      ub = int'(bv);
      ud = ua - ub - int'(bv_in);
      bo = (ud < 0);
      sa = $signed(av);
      sb = $signed(bv);
      sd = sa - sb - int'(bv_in);
      ov = (sd < -128) || (sd > 127);
      return {ov, bo, 8'((ud + 256) % 256)};
   endfunction

   task automatic check_result8(input string tag, input logic [9:0] e);
      check({tag, "_diff"}, 32'(diff8), 32'(e[7:0]));
      check({tag, "_bout"}, 32'(bout8), 32'(e[8]));
`ifdef SERIAL_SUB_OVERFLOW_EN
      check({tag, "_ovf"}, 32'(ovf8), 32'(e[9]));
`endif
   endtask

   task automatic release8(input string tag);
      out_ready8 = 1'b1;
      @(posedge clk); #1;
      out_ready8 = 1'b0;
      check({tag, "_ov_after"}, 32'(out_valid8), 32'd0);
      check({tag, "_ir_after"}, 32'(in_ready8), 32'd1);
   endtask

   // Runs one operation on the 8-bit instance up to DONE; optionally holds out_ready high throughout.
   task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic bv_in,
                      input bit hold_ready, input string tag);
      logic [9:0] e;
      int lat;
      exp_q.push_back(model8(av, bv, bv_in));
      out_ready8 = hold_ready;
      in_valid8 = 1'b1; a8 = av; b8 = bv; bin8 = bv_in;
      check({tag, "_in_ready"}, 32'(in_ready8), 32'd1);
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
      lat = 0;
      while (!out_valid8 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'd8);
      e = exp_q.pop_front();
      check_result8(tag, e);
      if (hold_ready) begin
         @(posedge clk); #1;
         out_ready8 = 1'b0;
         check({tag, "_ov_after"}, 32'(out_valid8), 32'd0);
         check({tag, "_ir_after"}, 32'(in_ready8), 32'd1);
      end
   endtask

   initial begin
      logic [9:0] e;
      logic [2:0] v;
      logic [1:0] full;

      in_valid8 = 0; a8 = 0; b8 = 0; bin8 = 0; out_ready8 = 0;
      in_valid1 = 0; a1 = 0; b1 = 0; bin1 = 0; out_ready1 = 0;

      #12;
      check("rst_in_ready", 32'(in_ready8), 32'd1);
      check("rst_out_valid", 32'(out_valid8), 32'd0);
      check("rst_diff", 32'(diff8), 32'd0);
      check("rst_bout", 32'(bout8), 32'd0);
`ifdef SERIAL_SUB_OVERFLOW_EN
      check("rst_ovf", 32'(ovf8), 32'd0);
`endif
      rst_n = 1'b1;
      @(posedge clk); #1;

      op8(8'h35, 8'h12, 1'b0, 1'b1, "basic");
      op8(8'h00, 8'h01, 1'b0, 1'b1, "wrap");
      op8(8'h10, 8'h10, 1'b1, 1'b1, "eq_bin");
      op8(8'h05, 8'h03, 1'b0, 1'b1, "early_ready");

      // Backpressure with new operands offered throughout
      e = model8(8'h9C, 8'h3E, 1'b0);
      op8(8'h9C, 8'h3E, 1'b0, 1'b0, "bp");
      in_valid8 = 1'b1; a8 = 8'h11; b8 = 8'h22; bin8 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("bp_out_valid", 32'(out_valid8), 32'd1);
         check("bp_in_ready", 32'(in_ready8), 32'd0);
         check_result8("bp_hold", e);
      end
      release8("bp");
      in_valid8 = 1'b0;
      @(posedge clk); #1;
      check("bp_no_capture", 32'(in_ready8), 32'd1);

      // Reset in the third SHIFT cycle aborts the operation
      in_valid8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; bin8 = 1'b0;
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", 32'(out_valid8), 32'd0);
      check("abort_diff", 32'(diff8), 32'd0);
      check("abort_bout", 32'(bout8), 32'd0);
      check("abort_in_ready", 32'(in_ready8), 32'd1);
      #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("abort_idle_ov", 32'(out_valid8), 32'd0);
      check("abort_idle_ir", 32'(in_ready8), 32'd1);
      op8(8'hAA, 8'h55, 1'b0, 1'b1, "after_rst");

      op8(8'h80, 8'h01, 1'b0, 1'b1, "ovf_neg");
      op8(8'h7F, 8'hFF, 1'b0, 1'b1, "ovf_pos");
      op8(8'h05, 8'h03, 1'b0, 1'b1, "ovf_none");

      // Random operands with random result-side stall
      for (int i = 0; i < 20; i++) begin
         op8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, "rand");
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         check("rand_hold_ov", 32'(out_valid8), 32'd1);
         release8("rand");
      end

      // WIDTH=1 truth-table sweep
      out_ready1 = 1'b1;
      for (int i = 0; i < 8; i++) begin
         v = 3'(i);
         full = {1'b0, v[2]} - {1'b0, v[1]} - {1'b0, v[0]};
         in_valid1 = 1'b1; a1 = v[2]; b1 = v[1]; bin1 = v[0];
         check("w1_in_ready", 32'(in_ready1), 32'd1);
         @(posedge clk); #1;
         in_valid1 = 1'b0;
         check("w1_shift_ov", 32'(out_valid1), 32'd0);
         @(posedge clk); #1;
         check("w1_out_valid", 32'(out_valid1), 32'd1);
         check("w1_diff", 32'(diff1), 32'(full[0]));
         check("w1_bout", 32'(bout1), 32'(full[1]));
         @(posedge clk); #1;
         check("w1_ov_after", 32'(out_valid1), 32'd0);
      end
      out_ready1 = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
